// File: rtl/cb_pkg.sv
// Shared constants for the connection-box config register map and word fields.
package cb_pkg;
  localparam logic [7:0] CB_ADDR_SHADOW = 8'd0;
  localparam logic [7:0] CB_ADDR_COMMIT = 8'd1;

  localparam int SEL_LSB     = 0;
  localparam int SEL_W       = 4;
  localparam int REG_OUT_BIT = 8;
  localparam int GATE_BIT    = 9;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             reg_out;
    logic             gate;
  } cb_cfg_t;

  function automatic cb_cfg_t cb_decode(input logic [31:0] word);
    cb_cfg_t c;
    c.sel     = word[SEL_LSB +: SEL_W];
    c.reg_out = word[REG_OUT_BIT];
    c.gate    = word[GATE_BIT];
    return c;
  endfunction
endpackage

// File: rtl/cb_mux.sv
// NUM_IN:1 track mux; out-of-range select or gate forces zero.
module cb_mux
  import cb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 10
) (
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    gate,
  output logic [WIDTH-1:0]        out
);
  logic [NUM_IN-1:0][WIDTH-1:0] trk;
  assign trk = in;

  always_comb begin
    out = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (!gate && sel == SEL_W'(k)) out = trk[k];
  end
endmodule

// File: rtl/cb_param.sv
// Configurable connection box: shadow/active config pair, track mux,
// optional one-cycle output register and config read-back.
module cb_param
  import cb_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          NUM_IN    = 10,
  parameter logic [31:0] RESET_CFG = 32'd13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in,
  output logic [WIDTH-1:0]        out,
  input  logic                    config_en,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_rd_en,
  output logic [31:0]             read_data
);
  logic [31:0]      shadow, active;
  logic [WIDTH-1:0] mux_res, out_q;
  logic [7:0]       reg_sel;
  cb_cfg_t          cfg;

  assign reg_sel = config_addr[31:24];
  assign cfg     = cb_decode(active);

  // Low address bits and non-field config bits carry no function.
  logic unused_bits;
  assign unused_bits = ^{config_addr[23:0], active[31:10], active[7:4]};

  cb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
    .in   (in),
    .sel  (cfg.sel),
    .gate (cfg.gate),
    .out  (mux_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= RESET_CFG;
      active    <= RESET_CFG;
      out_q     <= '0;
      read_data <= '0;
    end else begin
      // Register loads every cycle so a mode switch never exposes older data.
      out_q <= mux_res;
      if (config_en) begin
        if (reg_sel == CB_ADDR_SHADOW)      shadow <= config_data;
        else if (reg_sel == CB_ADDR_COMMIT) active <= shadow;
      end
      // Reads see pre-write values since all updates share this edge.
      if (config_rd_en) begin
        if (reg_sel == CB_ADDR_SHADOW)      read_data <= shadow;
        else if (reg_sel == CB_ADDR_COMMIT) read_data <= active;
        else                                read_data <= '0;
      end
    end
  end

  assign out = cfg.reg_out ? out_q : mux_res;
endmodule

// File: tb/tb_cb_param.sv
// Directed table-driven bench for cb_param with default parameters.
module tb_cb_param;
  localparam int WIDTH  = 16;
  localparam int NUM_IN = 10;
  localparam int NV     = 35;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in;
  logic [WIDTH-1:0]        out;
  logic                    config_en;
  logic [31:0]             config_addr;
  logic [31:0]             config_data;
  logic                    config_rd_en;
  logic [31:0]             read_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cb_param #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .RESET_CFG(32'd13)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .out          (out),
    .config_en    (config_en),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_rd_en (config_rd_en),
    .read_data    (read_data)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic en, input logic rd,
                              input logic [7:0] addr, input logic [31:0] data,
                              input logic [15:0] eo, input logic [31:0] er);
    vec_t v;
    v.rst = rst; v.en = en; v.rd = rd; v.addr = addr; v.data = data;
    v.exp_out = eo; v.exp_rd = er;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [15:0] exp);
    n_cmp++;
    if (out !== exp) begin
      n_err++;
      $display("FAIL %s: out=%h expected %h", name, out, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [31:0] exp);
    n_cmp++;
    if (read_data !== exp) begin
      n_err++;
      $display("FAIL %s: read_data=%h expected %h", name, read_data, exp);
    end
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    reset        = vecs[i].rst;
    config_en    = vecs[i].en;
    config_rd_en = vecs[i].rd;
    config_addr  = {vecs[i].addr, 24'h00abcd};
    config_data  = vecs[i].data;
    @(posedge clk);
    #1;
    check_out($sformatf("v%0d_out", i), vecs[i].exp_out);
    check_rd($sformatf("v%0d_rd", i), vecs[i].exp_rd);
  endtask

  initial begin
    reset = 1'b1; config_en = 1'b0; config_rd_en = 1'b0;
    config_addr = '0; config_data = '0;
    for (int k = 0; k < NUM_IN; k++) in[k*WIDTH +: WIDTH] = 16'h1000 + 16'(k);

    //               rst en rd addr  data          out       rd
    vecs[0]  = mk(1, 0, 0, 8'd0, 32'h0,       16'h0,    32'd0);
    vecs[1]  = mk(0, 0, 1, 8'd1, 32'h0,       16'h0,    32'd13);
    vecs[2]  = mk(0, 1, 0, 8'd0, 32'd3,       16'h0,    32'd13);
    vecs[3]  = mk(0, 0, 0, 8'd0, 32'h0,       16'h0,    32'd13);
    vecs[4]  = mk(0, 1, 0, 8'd1, 32'hdead,    16'h1003, 32'd13);
    vecs[5]  = mk(0, 0, 1, 8'd0, 32'h0,       16'h1003, 32'd3);
    vecs[6]  = mk(0, 1, 0, 8'd0, 32'h105,     16'h1003, 32'd3);
    vecs[7]  = mk(0, 1, 0, 8'd1, 32'h0,       16'h1003, 32'd3);
    vecs[8]  = mk(0, 0, 0, 8'd0, 32'h0,       16'h1005, 32'd3);
    // in5 becomes BEEF from here on
    vecs[9]  = mk(0, 1, 0, 8'd0, 32'h202,     16'hbeef, 32'd3);
    vecs[10] = mk(0, 1, 0, 8'd1, 32'h0,       16'h0,    32'd3);
    vecs[11] = mk(0, 1, 0, 8'd0, 32'd12,      16'h0,    32'd3);
    vecs[12] = mk(0, 1, 0, 8'd1, 32'h0,       16'h0,    32'd3);
    vecs[13] = mk(0, 1, 1, 8'd0, 32'd7,       16'h0,    32'd12);
    vecs[14] = mk(0, 0, 1, 8'd0, 32'h0,       16'h0,    32'd7);
    vecs[15] = mk(0, 1, 0, 8'd5, 32'hffff,    16'h0,    32'd7);
    vecs[16] = mk(0, 0, 1, 8'd5, 32'h0,       16'h0,    32'd0);
    vecs[17] = mk(0, 0, 1, 8'd0, 32'h0,       16'h0,    32'd7);
    vecs[18] = mk(0, 0, 1, 8'd1, 32'h0,       16'h0,    32'd12);
    vecs[19] = mk(0, 1, 1, 8'd1, 32'h0,       16'h1007, 32'd12);
    vecs[20] = mk(0, 0, 1, 8'd1, 32'h0,       16'h1007, 32'd7);
    vecs[21] = mk(1, 1, 1, 8'd0, 32'd5,       16'h0,    32'd0);
    vecs[22] = mk(0, 1, 0, 8'd0, 32'd3,       16'h0,    32'd0);
    vecs[23] = mk(1, 0, 0, 8'd0, 32'h0,       16'h0,    32'd0);
    vecs[24] = mk(0, 1, 0, 8'd1, 32'h0,       16'h0,    32'd0);
    vecs[25] = mk(0, 0, 1, 8'd1, 32'h0,       16'h0,    32'd13);
    vecs[26] = mk(0, 0, 1, 8'd0, 32'h0,       16'h0,    32'd13);
    vecs[27] = mk(0, 1, 0, 8'd0, 32'h104,     16'h0,    32'd13);
    vecs[28] = mk(0, 1, 0, 8'd1, 32'h0,       16'h0,    32'd13);
    vecs[29] = mk(0, 0, 0, 8'd0, 32'h0,       16'h1004, 32'd13);
    vecs[30] = mk(0, 1, 0, 8'd0, 32'd6,       16'h1004, 32'd13);
    vecs[31] = mk(0, 1, 0, 8'd1, 32'h0,       16'h1006, 32'd13);
    vecs[32] = mk(0, 1, 0, 8'd0, 32'h108,     16'h1006, 32'd13);
    vecs[33] = mk(0, 1, 0, 8'd1, 32'h0,       16'h1006, 32'd13);
    vecs[34] = mk(0, 0, 0, 8'd0, 32'h0,       16'h1008, 32'd13);

    for (int i = 0; i <= 8; i++) apply(i);

    // Registered mode: a track change reaches out one edge later.
    @(negedge clk);
    config_en = 1'b0; config_rd_en = 1'b0;
    in[5*WIDTH +: WIDTH] = 16'hbeef;
    #1;
    check_out("reg_hold_before_edge", 16'h1005);
    @(posedge clk);
    #1;
    check_out("reg_beef_after_edge", 16'hbeef);

    for (int i = 9; i < NV; i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cb_param.md
CB_PARAM -- requirements
Module: cb_param

Interface
REQ-001 Parameter WIDTH, default 16, data width of each input track and of out.
REQ-002 Parameter NUM_IN, default 10, number of input tracks (2..16).
REQ-003 Parameter RESET_CFG, default 32'd13, value loaded into shadow and active config on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in  input  NUM_IN*WIDTH  flattened tracks; track k occupies bits [k*WIDTH +: WIDTH].
REQ-007 out  output  WIDTH  selected track, combinational or registered per mode.
REQ-008 config_en  input  1  config write strobe.
REQ-009 config_addr  input  32  bits [31:24] select register; bits [23:0] ignored.
REQ-010 config_data  input  32  config write data.
REQ-011 config_rd_en  input  1  config read strobe.
REQ-012 read_data  output  32  config read-back data.

Function
REQ-013 Config word fields: SEL = bits [3:0]; REG_OUT = bit 8; GATE = bit 9; all other bits stored, no effect.
REQ-014 config_en=1 with addr[31:24]=0 shall write config_data into the shadow register next edge.
REQ-015 config_en=1 with addr[31:24]=1 shall copy shadow into active next edge; config_data ignored.
REQ-016 config_en=1 with any other addr[31:24] shall change no state.
REQ-017 Only the active register shall control the datapath; shadow writes alone do not change out.
REQ-018 Mux result = track SEL if SEL < NUM_IN and GATE=0; otherwise all zeros.
REQ-019 REG_OUT=0: out equals mux result combinationally (zero latency).
REQ-020 REG_OUT=1: out equals mux result captured at the previous edge (one-cycle latency).
REQ-021 Output register shall load mux result every cycle regardless of REG_OUT, so mode switch at commit shows no stale data older than one cycle.
REQ-022 Commit takes effect for out on the cycle after the commit edge (combinational mode) or one cycle later (registered mode).
REQ-023 config_rd_en=1 shall drive read_data on next edge: addr 0 -> shadow, addr 1 -> active, other -> 32'd0; otherwise read_data holds.
REQ-024 Simultaneous read and write of same register: read_data returns the pre-write value.
REQ-025 Commit in the same cycle as a read of addr 0 returns current shadow unchanged.

Reset
REQ-026 reset=1 at an edge: shadow = active = RESET_CFG, output register = 0, read_data = 0.
REQ-027 Reset shall take priority over config_en and config_rd_en in the same cycle.
REQ-028 With default RESET_CFG (SEL=13 >= NUM_IN) out shall be 0 after reset in both modes.
REQ-029 Reset asserted mid-operation discards any uncommitted shadow contents.

Structure
REQ-030 Shared package cb_pkg holds address constants (CB_ADDR_SHADOW=0, CB_ADDR_COMMIT=1) and field positions (SEL_LSB, SEL_W=4, REG_OUT_BIT=8, GATE_BIT=9).
REQ-031 One sub-module cb_mux: purely combinational NUM_IN:1 WIDTH-bit mux with out-of-range-to-zero behaviour.
REQ-032 Config registers, commit logic, output register and read-back remain in cb_param.

Verification
REQ-033 Reset, in track k = 16'h1000+k -> out=0, read addr 1 returns 32'd13.
REQ-034 Write addr0 data=3, no commit -> out stays 0; commit -> out=16'h1003 next cycle.
REQ-035 Write addr0 data=32'h105, commit -> out tracks in_5 one cycle late; change in_5 to 16'hBEEF -> out=16'hBEEF one cycle later.
REQ-036 Active SEL=2, write addr0 data=32'h202, commit -> out=0 (GATE); SEL=12 (>= NUM_IN) -> out=0.
REQ-037 Write addr0 data=7 with read addr0 same cycle -> read_data = old shadow; next read -> 32'd7; write addr 5 -> no state change, read addr 5 -> 0.
REQ-038 Shadow written, reset asserted before commit, then commit -> active = 32'd13, out=0.
